spi_seg_tx: RTL and testbench

SPI_SEG_TX -- requirements
Module: spi_seg_tx

---
 rtl/spi_seg_pkg.sv | 24 ++
 rtl/spi_seg_tx_seg7_encoder.sv | 15 +
 rtl/spi_seg_tx.sv | 180 ++++++++++++++++++
 tb/tb_spi_seg_tx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_seg_pkg.sv
// spi_seg_pkg
//   Shared types and constants for the SPI seven-segment transmitter:
//   - DIV_W   : width of the SCLK half-period down-counter
//   - state_e : transmit sequencer states
//   - SEG_LUT : hex digit -> segment pattern, active-high, a..g in bits 0..6
package spi_seg_pkg;

  localparam int DIV_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  // Packed so that SEG_LUT[n] is the pattern for digit n (first element is index 15).
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/spi_seg_tx_seg7_encoder.sv
// seg7_encoder
//   Combinational hex-nibble to seven-segment encoder.
//   Ports:
//     nibble_i [3:0] : hex digit 0..F
//     seg_o    [6:0] : segment pattern, active-high, a..g in bits 0..6
module seg7_encoder
  import spi_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[nibble_i];

endmodule

// File: rtl/spi_seg_tx.sv
// spi_seg_tx
//   Sends one byte per request to a seven-segment driver over SPI mode 0,
//   MSB first, optionally encoding a hex nibble (plus decimal point) first.
//   Ports:
//     clk, rst_n       : clock, asynchronous active-low reset
//     tx_data [7:0]    : raw segment byte, or hex nibble in [3:0] with DP in [7]
//     tx_hex           : 1 = encode tx_data[3:0], 0 = send tx_data as is
//     tx_valid/tx_ready: request handshake, accepted when both are high
//     spi_sclk/mosi/cs_n : SPI bus, all driven from flops
//     frame_done       : one-cycle pulse coincident with the chip-select rise
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | bus idle, ready for a request
//   SETUP  | CS low, MSB on MOSI, waiting CLK_DIV cycles before first rise
//   SHIFT  | 16 SCLK half-periods (8 pulses), MOSI advances on falling edges
//   HOLD   | SCLK low, MOSI holds bit 0, for CLK_DIV cycles
//   GAP    | CS high for CLK_DIV cycles; a new request may land on its last edge
module spi_seg_tx
  import spi_seg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_hex,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic       frame_done
);

  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       half_q, half_d;
  logic [7:0]       sreg_q, sreg_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic [6:0]       seg;
  logic [7:0]       payload;
  logic             div_tc;
  logic             accept;

  seg7_encoder u_enc (
    .nibble_i (tx_data[3:0]),
    .seg_o    (seg)
  );

  assign payload = tx_hex ? {tx_data[7], seg} : tx_data;
  assign div_tc  = (div_q == '0);
  assign accept  = tx_valid && ready_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    sreg_d  = sreg_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    ready_d = ready_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (accept) begin
          state_d = ST_SETUP;
          div_d   = DIV_RELOAD;
          sreg_d  = payload;
          mosi_d  = payload[7];
          cs_n_d  = 1'b0;
          ready_d = 1'b0;
        end else if (state_q == ST_GAP) begin
          if (div_tc) begin
            state_d = ST_IDLE;
          end else begin
            div_d = div_q - 1'b1;
            // Ready rises for the last GAP cycle so the next frame can be
            // accepted exactly when GAP ends, keeping the CS-high gap at CLK_DIV.
            if (div_q == DIV_ONE) ready_d = 1'b1;
          end
        end
      end

      ST_SETUP: begin
        if (div_tc) begin
          state_d = ST_SHIFT;
          div_d   = DIV_RELOAD;
          half_d  = 4'd0;
          sclk_d  = 1'b1;
        end else begin
          div_d = div_q - 1'b1;
        end
      end

      ST_SHIFT: begin
        if (div_tc) begin
          div_d = DIV_RELOAD;
          if (half_q == 4'd15) begin
            state_d = ST_HOLD;
          end else begin
            half_d = half_q + 4'd1;
            if (!half_q[0]) begin
              sclk_d = 1'b0;
              // The 8th falling edge (half 14) leaves bit 0 on MOSI for HOLD.
              if (half_q != 4'd14) begin
                sreg_d = {sreg_q[6:0], 1'b0};
                mosi_d = sreg_q[6];
              end
            end else begin
              sclk_d = 1'b1;
            end
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end

      ST_HOLD: begin
        if (div_tc) begin
          state_d = ST_GAP;
          div_d   = DIV_RELOAD;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          if (CLK_DIV == 1) ready_d = 1'b1;
        end else begin
          div_d = div_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        sclk_d  = 1'b0;
        cs_n_d  = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      half_q  <= 4'd0;
      sreg_q  <= 8'd0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      sreg_q  <= sreg_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign tx_ready   = ready_q;
  assign spi_sclk   = sclk_q;
  assign spi_mosi   = mosi_q;
  assign spi_cs_n   = cs_n_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_spi_seg_tx.sv
module tb_spi_seg_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a: CLK_DIV=2, dut_b: CLK_DIV=1
  logic       rst_a, valid_a, hex_a, ready_a, sclk_a, mosi_a, cs_a, done_a;
  logic [7:0] data_a;
  logic       rst_b, valid_b, hex_b, ready_b, sclk_b, mosi_b, cs_b, done_b;
  logic [7:0] data_b;

  spi_seg_tx #(.CLK_DIV(2)) dut_a (
    .clk(clk), .rst_n(rst_a), .tx_data(data_a), .tx_hex(hex_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .spi_sclk(sclk_a), .spi_mosi(mosi_a), .spi_cs_n(cs_a),
    .frame_done(done_a)
  );

  spi_seg_tx #(.CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_b), .tx_data(data_b), .tx_hex(hex_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .spi_sclk(sclk_b), .spi_mosi(mosi_b), .spi_cs_n(cs_b),
    .frame_done(done_b)
  );

  int vec = 0;
  int err = 0;

  // Bus monitors: MOSI sampled on SCLK rises, running counts never cleared.
  logic [7:0]  shift_a = 8'd0;
  logic [23:0] shift_b = 24'd0;
  int rises_a = 0, rises_b = 0, dones_a = 0;
  int prot_a = 0, prot_b = 0;
  logic pm_a = 1'b0, pm_b = 1'b0;

  always @(posedge sclk_a) begin
    shift_a <= {shift_a[6:0], mosi_a};
    rises_a <= rises_a + 1;
  end

  always @(posedge sclk_b) begin
    shift_b <= {shift_b[22:0], mosi_b};
    rises_b <= rises_b + 1;
  end

  // Protocol watch: SCLK never high with CS high; MOSI never changes while SCLK high.
  always @(posedge clk) begin
    #3;
    if (sclk_a === 1'b1 && cs_a === 1'b1) prot_a++;
    if (sclk_a === 1'b1 && mosi_a !== pm_a) prot_a++;
    pm_a = mosi_a;
    if (done_a === 1'b1) dones_a++;
    if (sclk_b === 1'b1 && cs_b === 1'b1) prot_b++;
    if (sclk_b === 1'b1 && mosi_b !== pm_b) prot_b++;
    pm_b = mosi_b;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    valid_a = 1'b0; hex_a = 1'b0; data_a = 8'h00;
    valid_b = 1'b0; hex_b = 1'b0; data_b = 8'h00;
    repeat (3) tick();
    vec++; if (cs_a !== 1'b1)    begin err++; $display("FAIL reset_cs_n got=%b exp=1", cs_a); end
    vec++; if (sclk_a !== 1'b0)  begin err++; $display("FAIL reset_sclk got=%b exp=0", sclk_a); end
    vec++; if (mosi_a !== 1'b0)  begin err++; $display("FAIL reset_mosi got=%b exp=0", mosi_a); end
    vec++; if (done_a !== 1'b0)  begin err++; $display("FAIL reset_done got=%b exp=0", done_a); end
    vec++; if (ready_a !== 1'b1) begin err++; $display("FAIL reset_ready got=%b exp=1", ready_a); end
    vec++; if (cs_b !== 1'b1)    begin err++; $display("FAIL reset_cs_n_b got=%b exp=1", cs_b); end
    vec++; if (ready_b !== 1'b1) begin err++; $display("FAIL reset_ready_b got=%b exp=1", ready_b); end
    rst_a = 1'b1; rst_b = 1'b1;
    tick();
  endtask

  // One frame on dut_a (CLK_DIV=2). k counts clk edges after the acceptance edge E0;
  // values sampled after edge E0+k are what the next edge E0+k+1 sees.
  task automatic send_frame_a(input logic [7:0] d, input logic hx, input logic [7:0] exp,
                              input bit disturb, input string nm);
    int w, r0, cs_low, cs_rise, first_rdy, dn, done_at;
    w = 0;
    while (ready_a !== 1'b1 && w < 100) begin tick(); w++; end
    vec++; if (ready_a !== 1'b1) begin err++; $display("FAIL %s ready_wait got=%b exp=1", nm, ready_a); end
    r0 = rises_a;
    data_a = d; hex_a = hx; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    vec++; if (cs_a !== 1'b0)    begin err++; $display("FAIL %s e0_cs_n got=%b exp=0", nm, cs_a); end
    vec++; if (ready_a !== 1'b0) begin err++; $display("FAIL %s e0_ready got=%b exp=0", nm, ready_a); end
    vec++; if (mosi_a !== exp[7]) begin err++; $display("FAIL %s e0_mosi got=%b exp=%b", nm, mosi_a, exp[7]); end
    cs_low = (cs_a === 1'b0) ? 1 : 0;
    cs_rise = -1; first_rdy = -1; dn = 0; done_at = -1;
    for (int k = 1; k <= 44; k++) begin
      if (disturb && k >= 2 && k <= 30) begin
        valid_a = k[0]; data_a = ~d; hex_a = ~hx;
      end
      if (disturb && k == 31) valid_a = 1'b0;
      tick();
      if (cs_rise < 0 && cs_a === 1'b0) cs_low++;
      if (cs_rise < 0 && cs_a === 1'b1) cs_rise = k;
      if (done_a === 1'b1) begin dn++; if (done_at < 0) done_at = k; end
      if (first_rdy < 0 && ready_a === 1'b1) first_rdy = k;
    end
    vec++; if (shift_a !== exp) begin err++; $display("FAIL %s byte got=%h exp=%h", nm, shift_a, exp); end
    vec++; if (rises_a - r0 != 8) begin err++; $display("FAIL %s sclk_rises got=%0d exp=8", nm, rises_a - r0); end
    vec++; if (cs_low != 36)  begin err++; $display("FAIL %s cs_low_cycles got=%0d exp=36", nm, cs_low); end
    vec++; if (cs_rise != 36) begin err++; $display("FAIL %s cs_rise_at got=%0d exp=36", nm, cs_rise); end
    vec++; if (dn != 1 || done_at != 36) begin err++; $display("FAIL %s frame_done got=%0d@%0d exp=1@36", nm, dn, done_at); end
    // High after edge E0+37, so edge E0+38 sees tx_ready=1.
    vec++; if (first_rdy != 37) begin err++; $display("FAIL %s ready_return got=%0d exp=37", nm, first_rdy); end
    vec++; if (cs_a !== 1'b1 || ready_a !== 1'b1) begin err++; $display("FAIL %s idle_after got=cs%b/rdy%b exp=cs1/rdy1", nm, cs_a, ready_a); end
  endtask

  task automatic test_raw();
    send_frame_a(8'hA5, 1'b0, 8'hA5, 1'b0, "raw_A5");
  endtask

  task automatic test_hex();
    send_frame_a(8'h83, 1'b1, 8'hCF, 1'b0, "hex_83");
    send_frame_a(8'h0F, 1'b1, 8'h71, 1'b0, "hex_0F");
    send_frame_a(8'h8B, 1'b1, 8'hFC, 1'b0, "hex_8B");
    send_frame_a(8'h06, 1'b1, 8'h7D, 1'b0, "hex_06");
  endtask

  task automatic test_payload_hold();
    send_frame_a(8'hC3, 1'b0, 8'hC3, 1'b1, "hold_C3");
  endtask

  task automatic test_reset_mid();
    int w, r0, d0;
    r0 = rises_a;
    data_a = 8'hFF; hex_a = 1'b0; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    w = 0;
    while (rises_a - r0 < 4 && w < 40) begin tick(); w++; end
    vec++; if (rises_a - r0 != 4) begin err++; $display("FAIL rstmid_rises got=%0d exp=4", rises_a - r0); end
    d0 = dones_a;
    #3 rst_a = 1'b0;
    #1;
    vec++; if (cs_a !== 1'b1)    begin err++; $display("FAIL rstmid_cs_n got=%b exp=1", cs_a); end
    vec++; if (sclk_a !== 1'b0)  begin err++; $display("FAIL rstmid_sclk got=%b exp=0", sclk_a); end
    vec++; if (ready_a !== 1'b1) begin err++; $display("FAIL rstmid_ready got=%b exp=1", ready_a); end
    tick();
    tick();
    rst_a = 1'b1;
    vec++; if (dones_a != d0) begin err++; $display("FAIL rstmid_no_done got=%0d exp=%0d", dones_a, d0); end
    send_frame_a(8'h3C, 1'b0, 8'h3C, 1'b0, "post_reset_3C");
  endtask

  task automatic test_back_to_back();
    int lows[3];
    int gaps[2];
    int falls, run, dones, r0;
    logic prev;
    lows = '{-1, -1, -1};
    gaps = '{-1, -1};
    falls = 0; run = 0; dones = 0; prev = 1'b1;
    r0 = rises_b;
    data_b = 8'h5A; hex_b = 1'b0; valid_b = 1'b1;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (done_b === 1'b1) dones++;
      if (cs_b !== prev) begin
        if (prev === 1'b1 && falls >= 1 && falls <= 2) gaps[falls-1] = run;
        if (prev === 1'b0 && falls >= 1 && falls <= 3) lows[falls-1] = run;
        if (cs_b === 1'b0) begin
          falls++;
          if (falls == 3) valid_b = 1'b0;
        end
        run = 0;
      end
      run++;
      prev = cs_b;
    end
    vec++; if (falls != 3) begin err++; $display("FAIL b2b_frames got=%0d exp=3", falls); end
    vec++; if (lows[0] != 18 || lows[1] != 18 || lows[2] != 18)
      begin err++; $display("FAIL b2b_cs_low got=%0d,%0d,%0d exp=18,18,18", lows[0], lows[1], lows[2]); end
    vec++; if (gaps[0] != 1 || gaps[1] != 1)
      begin err++; $display("FAIL b2b_gap got=%0d,%0d exp=1,1", gaps[0], gaps[1]); end
    vec++; if (rises_b - r0 != 24) begin err++; $display("FAIL b2b_sclk_rises got=%0d exp=24", rises_b - r0); end
    vec++; if (dones != 3) begin err++; $display("FAIL b2b_frame_done got=%0d exp=3", dones); end
    vec++; if (shift_b !== 24'h5A5A5A) begin err++; $display("FAIL b2b_bytes got=%h exp=5a5a5a", shift_b); end
  endtask

  task automatic test_protocol();
    vec++; if (prot_a != 0) begin err++; $display("FAIL protocol_a violations got=%0d exp=0", prot_a); end
    vec++; if (prot_b != 0) begin err++; $display("FAIL protocol_b violations got=%0d exp=0", prot_b); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_hex();
    test_payload_hold();
    test_reset_mid();
    test_back_to_back();
    repeat (4) tick();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
